clock_monitor: RTL and testbench

Receive-side checker for the divided clocks produced by the clock generator. It samples one monitored clock (`mon_in`) in the `clk_in` domain and measures each period and its high time in `clk_in` cycles. It compares both against expected values supplied at run time, and reports per-period measurements, mismatches, stalls, lock status and a saturating error count. One instance is placed per divided output under test.

---
 rtl/clock_monitor_if.sv | 39 +++
 rtl/clock_monitor.sv | 181 ++++++++++++++++++
 tb/tb_clock_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/clock_monitor_if.sv
// Purpose: bundles the monitored clock, expected values and measurement results of clock_monitor.
// Latency: none (wires only).
// Backpressure: none; results are pulses or levels with no ready path.
//
// Signals:
//   mon_in      - monitored divided clock (driven by master)
//   exp_period  - expected period in clk_in cycles (driven by master)
//   exp_high    - expected high time in clk_in cycles (driven by master)
//   period      - last measured period (driven by slave)
//   high_time   - last measured high time (driven by slave)
//   meas_valid  - one-cycle pulse when period/high_time update (driven by slave)
//   mismatch    - one-cycle pulse with meas_valid when measurement differs (driven by slave)
//   stall       - one-cycle pulse when no rising edge arrives within the limit (driven by slave)
//   locked      - level, enough consecutive matches seen (driven by slave)
//   err_count   - saturating count of mismatches plus stalls (driven by slave)
interface clock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             mon_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             mismatch;
  logic             stall;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output mon_in, exp_period, exp_high,
    input  period, high_time, meas_valid, mismatch, stall, locked, err_count
  );

  modport slave (
    input  mon_in, exp_period, exp_high,
    output period, high_time, meas_valid, mismatch, stall, locked, err_count
  );
endinterface

// File: rtl/clock_monitor.sv
// Purpose: measures period and high time of a divided clock in clk_in cycles and checks them
//          against run-time expected values; reports mismatch, stall, lock and an error count.
// Latency: mon_in to sample 1 cycle (3 with CLOCK_MONITOR_SYNC_EN); results registered 1 cycle
//          after the completing rising edge. Backpressure: none, observer only.
//
// Ports:
//   clk_in - system clock, all registers on its rising edge
//   rst    - asynchronous active-high reset
//   bus    - clock_monitor_if.slave (mon_in, exp_period, exp_high in; measurements out)
//
// Configuration macro CLOCK_MONITOR_SYNC_EN: when defined, mon_in passes through a
// 2-flop synchronizer ahead of the sample register (for asynchronous monitored clocks).
module clock_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic                 clk_in,
  input  logic                 rst,
  clock_monitor_if.slave       bus
);

  localparam int               MW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Input sampling
  logic mon_samp;

`ifdef CLOCK_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.mon_in};
  end

  assign mon_samp = sync_q[1];
`else
  assign mon_samp = bus.mon_in;
`endif

  logic s_q, s_d_q;
  logic rise;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s_q   <= 1'b0;
      s_d_q <= 1'b0;
    end else begin
      s_q   <= mon_samp;
      s_d_q <= s_q;
    end
  end

  assign rise = s_q & ~s_d_q;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_q, meas_d;
  logic             mis_q, mis_d;
  logic             stall_q, stall_d;
  logic [MW-1:0]    match_q, match_d;
  logic [7:0]       err_q, err_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      meas_q   <= 1'b0;
      mis_q    <= 1'b0;
      stall_q  <= 1'b0;
      match_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      meas_q   <= meas_d;
      mis_q    <= mis_d;
      stall_q  <= stall_d;
      match_q  <= match_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    meas_d   = 1'b0;
    mis_d    = 1'b0;
    stall_d  = 1'b0;
    match_d  = match_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        per_d = '0;
        hi_d  = '0;
        // First edge only starts a window; nothing to report yet.
        if (rise) begin
          state_d = HIGH;
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
        end
      end
      HIGH: begin
        if (per_q == CNT_MAX) begin
          stall_d = 1'b1;
        end else begin
          per_d = per_q + CNT_W'(1);
          if (s_q) hi_d    = hi_q + CNT_W'(1);
          else     state_d = LOW;
        end
      end
      LOW: begin
        // Limit check first so a stall wins over a coincident rise.
        if (per_q == CNT_MAX) begin
          stall_d = 1'b1;
        end else if (rise) begin
          meas_d   = 1'b1;
          period_d = per_q;
          high_d   = hi_q;
          state_d  = HIGH;
          per_d    = CNT_W'(1);
          hi_d     = CNT_W'(1);
        end else begin
          per_d = per_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        per_d   = '0;
        hi_d    = '0;
      end
    endcase

    if (stall_d) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      match_d = '0;
    end

    // Expected values are sampled only at the completing edge.
    if (meas_d) begin
      if ((per_q != bus.exp_period) || (hi_q != bus.exp_high)) begin
        mis_d   = 1'b1;
        match_d = '0;
      end else if (match_q != LOCK_N) begin
        match_d = match_q + MW'(1);
      end
    end

    if ((mis_d || stall_d) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = meas_q;
  assign bus.mismatch   = mis_q;
  assign bus.stall      = stall_q;
  assign bus.locked     = (match_q == LOCK_N);
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Purpose: directed self-checking bench for clock_monitor (CNT_W=8, LOCK_COUNT=3).
// Latency: checks are relative to observed pulses, so both synchronizer builds apply.
// Backpressure: n/a.
module tb_clock_monitor;

  logic clk_in;
  logic rst;

  clock_monitor_if #(.CNT_W(8)) bus ();

  clock_monitor #(.CNT_W(8), .LOCK_COUNT(3)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors    = 0;
  int miscompares = 0;

  // Pulse bookkeeping, sampled away from the active edge.
  int   cyc         = 0;
  int   n_meas      = 0;
  int   n_mis       = 0;
  int   n_stall     = 0;
  int   meas_t_prev = 0;
  int   meas_t_last = 0;
  int   stall_t     = 0;
  logic lock_at [0:1023];

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (bus.meas_valid === 1'b1) begin
      if (n_meas < 1024) lock_at[n_meas] = bus.locked;
      n_meas      = n_meas + 1;
      meas_t_prev = meas_t_last;
      meas_t_last = cyc;
    end
    if (bus.mismatch === 1'b1) n_mis = n_mis + 1;
    if (bus.stall === 1'b1) begin
      n_stall = n_stall + 1;
      stall_t = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic m);
    bus.mon_in = m;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},   32'(bus.period),     0);
    chk({tag, "_high"},     32'(bus.high_time),  0);
    chk({tag, "_meas"},     32'(bus.meas_valid), 0);
    chk({tag, "_mismatch"}, 32'(bus.mismatch),   0);
    chk({tag, "_stall"},    32'(bus.stall),      0);
    chk({tag, "_locked"},   32'(bus.locked),     0);
    chk({tag, "_err"},      32'(bus.err_count),  0);
  endtask

  initial begin
    int m0, mis0, st0, tlast;

    rst            = 1'b1;
    bus.mon_in     = 1'b0;
    bus.exp_period = 8'd4;
    bus.exp_high   = 8'd2;
    repeat (2) @(posedge clk_in);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Divide-by-4, matching expectations.
    idle(3);
    m0 = n_meas; mis0 = n_mis;
    wave(2, 2, 6);
    idle(4);
    chk("div4_meas_count", 32'(n_meas - m0), 5);
    chk("div4_mismatches", 32'(n_mis - mis0), 0);
    chk("div4_period",     32'(bus.period), 4);
    chk("div4_high",       32'(bus.high_time), 2);
    chk("div4_spacing",    32'(meas_t_last - meas_t_prev), 4);
    chk("div4_lock_2nd",   32'(lock_at[m0 + 1]), 0);
    chk("div4_lock_3rd",   32'(lock_at[m0 + 2]), 1);
    chk("div4_locked",     32'(bus.locked), 1);
    chk("div4_err",        32'(bus.err_count), 0);

    // Hold low after lock: stall 255 cycles after the last measurement.
    st0 = n_stall; tlast = meas_t_last;
    for (int i = 0; i < 300 && n_stall == st0; i++) tick(1'b0);
    idle(2);
    chk("stall_seen",   32'(n_stall - st0), 1);
    chk("stall_delay",  32'(stall_t - tlast), 255);
    chk("stall_period", 32'(bus.period), 4);
    chk("stall_high",   32'(bus.high_time), 2);
    chk("stall_locked", 32'(bus.locked), 0);
    chk("stall_err",    32'(bus.err_count), 1);
    m0 = n_meas;
    wave(2, 2, 2);
    idle(4);
    chk("stall_two_rises_one_meas", 32'(n_meas - m0), 1);
    chk("stall_relock_period",      32'(bus.period), 4);

    // Relock, then reset mid-LOW.
    wave(2, 2, 4);
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    chk("prereset_locked", 32'(bus.locked), 1);
    m0 = n_meas;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    idle(3);
    chk("midrst_no_meas", 32'(n_meas - m0), 0);
    rst = 1'b0;
    wave(2, 2, 1);
    idle(4);
    chk("postrst_first_rise", 32'(n_meas - m0), 0);
    wave(2, 2, 1);
    idle(4);
    chk("postrst_second_rise", 32'(n_meas - m0), 1);
    chk("postrst_period",      32'(bus.period), 8);
    chk("postrst_high",        32'(bus.high_time), 2);
    chk("postrst_err",         32'(bus.err_count), 1);
    chk("postrst_locked",      32'(bus.locked), 0);

    // Divide-by-5 (3 high / 2 low) against 5/2: every measurement mismatches.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.exp_period = 8'd5;
    bus.exp_high   = 8'd2;
    m0 = n_meas; mis0 = n_mis;
    wave(3, 2, 6);
    idle(4);
    chk("div5_meas_count", 32'(n_meas - m0), 5);
    chk("div5_mismatches", 32'(n_mis - mis0), 5);
    chk("div5_period",     32'(bus.period), 5);
    chk("div5_high",       32'(bus.high_time), 3);
    chk("div5_lock_3rd",   32'(lock_at[m0 + 2]), 0);
    chk("div5_locked",     32'(bus.locked), 0);
    chk("div5_err",        32'(bus.err_count), 5);
    wave(3, 2, 300);
    chk("err_saturate", 32'(bus.err_count), 255);
    wave(3, 2, 5);
    chk("err_no_wrap",  32'(bus.err_count), 255);

    // Divide-by-2, back-to-back measurements.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.exp_period = 8'd2;
    bus.exp_high   = 8'd1;
    idle(3);
    m0 = n_meas; mis0 = n_mis;
    wave(1, 1, 8);
    idle(4);
    chk("div2_meas_count", 32'(n_meas - m0), 7);
    chk("div2_spacing",    32'(meas_t_last - meas_t_prev), 2);
    chk("div2_mismatches", 32'(n_mis - mis0), 0);
    chk("div2_period",     32'(bus.period), 2);
    chk("div2_high",       32'(bus.high_time), 1);
    chk("div2_lock_2nd",   32'(lock_at[m0 + 1]), 0);
    chk("div2_lock_3rd",   32'(lock_at[m0 + 2]), 1);
    chk("div2_err",        32'(bus.err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
